// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the coprocessor-0 slice: register
//               indices, field bit positions, exception codes, the handler
//               vector, and helpers that pack SR/Cause for mfc0 reads.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register indices as seen by mfc0/mtc0
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    // Field bit positions inside SR and Cause
    localparam int BIT_IE      = 0;
    localparam int BIT_EXL     = 1;
    localparam int BIT_EXC_LO  = 2;
    localparam int EXC_BITS    = 5;
    localparam int BIT_IM_BASE = 10;
    localparam int BIT_BD      = 31;

    // Six interrupt slots span bits 15:10; the top slot doubles as the timer
    localparam int IRQ_SLOTS   = 6;
    localparam int TIMER_SLOT  = 5;

    // Exception codes recorded in Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Redirect target used by the core when req is taken
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    // Assemble the architectural SR view; unimplemented bits read 0
    function automatic logic [31:0] pack_sr(input logic [IRQ_SLOTS-1:0] im,
                                            input logic exl, input logic ie);
        logic [31:0] r;
        r = '0;
        r[BIT_IM_BASE +: IRQ_SLOTS] = im;
        r[BIT_EXL] = exl;
        r[BIT_IE]  = ie;
        return r;
    endfunction

    // Assemble the architectural Cause view; unimplemented bits read 0
    function automatic logic [31:0] pack_cause(input logic bd,
                                               input logic [IRQ_SLOTS-1:0] ip,
                                               input logic [EXC_BITS-1:0] exc);
        logic [31:0] r;
        r = '0;
        r[BIT_BD] = bd;
        r[BIT_IM_BASE +: IRQ_SLOTS] = ip;
        r[BIT_EXC_LO +: EXC_BITS] = exc;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer. Count free-runs and wraps; a pending
//               flag latches when Count matches Compare and is cleared by
//               writing Compare. Only built when CP0_TIMER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pend_o
);
    import cp0_pkg::*;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q, pend_d;

    // Next-state: a Count write replaces that cycle's increment; a Compare
    // write takes precedence over a coincident match so the clear sticks
    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + 32'd1;
        compare_d = compare_we_i ? wdata_i : compare_q;
        pend_d    = pend_q;
        if (compare_we_i) begin
            pend_d = 1'b0;
        end else if (count_q == compare_q) begin
            pend_d = 1'b1;
        end
    end

    // Timer state registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            compare_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pend_o    = pend_q;

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_unit
// Description : M-stage coprocessor 0 holding SR, Cause, EPC and PRId.
//               Arbitrates hardware interrupts against the pipe's exception
//               code and raises a single combinational flush request.
//               Optional Count/Compare timer enabled by macro CP0_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h0000_7000,
    parameter int          EXC_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [EXC_W-1:0]     exccode_in,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 eret,
    output logic                 req,
    output logic [31:0]          epc_out
);
    import cp0_pkg::*;

    // Slots backed by a real interrupt source; IM bits outside it stay 0
    localparam logic [IRQ_SLOTS-1:0] HW_MASK =
        IRQ_SLOTS'((7'd1 << NUM_HWINT) - 7'd1);
`ifdef CP0_TIMER_EN
    localparam logic [IRQ_SLOTS-1:0] IM_MASK =
        HW_MASK | (IRQ_SLOTS'(1) << TIMER_SLOT);
`else
    localparam logic [IRQ_SLOTS-1:0] IM_MASK = HW_MASK;
`endif

    logic [IRQ_SLOTS-1:0] im_q, im_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic [EXC_BITS-1:0]  exc_q, exc_d;
    logic [IRQ_SLOTS-1:0] ip_q, ip_d;
    logic [31:0]          epc_q, epc_d;

    logic [IRQ_SLOTS-1:0] w_hw6;
    logic [IRQ_SLOTS-1:0] w_pend6;
    logic [IRQ_SLOTS-1:0] w_ip_read;
    logic                 w_int_req;
    logic                 w_exc_req;
    logic [31:0]          w_vpc_adj;

    assign w_hw6 = IRQ_SLOTS'(hwint);

`ifdef CP0_TIMER_EN
    logic        timer_pend;
    logic [31:0] count_val;
    logic [31:0] compare_val;

    generate
        if (NUM_HWINT > 5) begin : g_timer_slot_clash
            $error("cp0_unit: CP0_TIMER_EN needs NUM_HWINT <= 5 (slot 15 is the timer)");
        end
    endgenerate

    // Timer writes are subject to the same exception-wins rule as SR/EPC
    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .count_we_i   (we && !req && (addr == REG_COUNT)),
        .compare_we_i (we && !req && (addr == REG_COMPARE)),
        .wdata_i      (wdata),
        .count_o      (count_val),
        .compare_o    (compare_val),
        .pend_o       (timer_pend)
    );

    assign w_pend6   = w_hw6 | ({{(IRQ_SLOTS-1){1'b0}}, timer_pend} << TIMER_SLOT);
    assign w_ip_read = ip_q  | ({{(IRQ_SLOTS-1){1'b0}}, timer_pend} << TIMER_SLOT);
`else
    assign w_pend6   = w_hw6;
    assign w_ip_read = ip_q;
`endif

    // Interrupts sample the live lines so the request has no added latency
    assign w_int_req = ie_q & ~exl_q & (|(w_pend6 & im_q));
    assign w_exc_req = ~exl_q & (exccode_in != '0);
    assign req       = w_int_req | w_exc_req;

    // Delay-slot instructions resume at the branch, one word earlier
    assign w_vpc_adj = vpc - (bd_in ? 32'd4 : 32'd0);

    // Forward a same-cycle EPC write so mtc0 EPC followed by eret resolves
    assign epc_out = (we && (addr == REG_EPC)) ? {wdata[31:2], 2'b00} : epc_q;

    // Next-state: exception entry overrides mtc0; eret applies last
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = w_hw6;
        if (req) begin
            exl_d = 1'b1;
            exc_d = w_int_req ? EXC_INT : EXC_BITS'(exccode_in);
            bd_d  = bd_in;
            epc_d = w_vpc_adj & ~32'd3;
        end else begin
            if (we && (addr == REG_SR)) begin
                im_d  = wdata[BIT_IM_BASE +: IRQ_SLOTS] & IM_MASK;
                exl_d = wdata[BIT_EXL];
                ie_d  = wdata[BIT_IE];
            end
            if (we && (addr == REG_EPC)) begin
                epc_d = wdata & ~32'd3;
            end
            if (eret) begin
                exl_d = 1'b0;
            end
        end
    end

    // Architectural CP0 state, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            exc_q <= '0;
            ip_q  <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            exc_q <= exc_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

    // mfc0 read mux returns pre-write register contents
    always_comb begin
        rdata = '0;
        case (addr)
            REG_SR:      rdata = pack_sr(im_q, exl_q, ie_q);
            REG_CAUSE:   rdata = pack_cause(bd_q, w_ip_read, exc_q);
            REG_EPC:     rdata = epc_q;
            REG_PRID:    rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
            REG_COUNT:   rdata = count_val;
            REG_COMPARE: rdata = compare_val;
`endif
            default:     rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_unit
// Description : Scoreboard bench for cp0_unit. Stimulus queues expected
//               output values; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;
    import cp0_pkg::*;

`ifdef CP0_TIMER_EN
    localparam int NHW = 5;
`else
    localparam int NHW = 6;
`endif
    localparam logic [31:0] PRID = 32'h0000_7000;

    localparam int K_REQ = 0;
    localparam int K_RD  = 1;
    localparam int K_EPC = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            we;
    logic [4:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [31:0]     vpc;
    logic            bd_in;
    logic [4:0]      exccode_in;
    logic [NHW-1:0]  hwint;
    logic            eret;
    logic            req;
    logic [31:0]     epc_out;

    cp0_unit #(.NUM_HWINT(NHW), .PRID_VAL(PRID), .EXC_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exccode_in (exccode_in),
        .hwint      (hwint),
        .eret       (eret),
        .req        (req),
        .epc_out    (epc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: everything queued since the last edge is checked mid-cycle
    always @(negedge clk) begin : mon
        chk_t        c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            case (c.kind)
                K_REQ:   act = {31'd0, req};
                K_RD:    act = rdata;
                default: act = epc_out;
            endcase
            n_cmp++;
            if (act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic push(input string n, input int k, input logic [31:0] v);
        sb.push_back('{n, k, v});
    endtask

    task automatic rd(input string n, input logic [4:0] a, input logic [31:0] v);
        addr = a;
        push(n, K_RD, v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; addr = '0; wdata = '0; vpc = '0; bd_in = 1'b0;
        exccode_in = '0; hwint = '0; eret = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        rd("rst_cause", REG_CAUSE, 32'h0); push("rst_req", K_REQ, 0); step();
        rd("rst_sr", REG_SR, 32'h0); step();
        rd("rst_epc", REG_EPC, 32'h0); push("rst_epc_out", K_EPC, 32'h0); step();
        rd("rst_prid", REG_PRID, PRID); step();
        rd("rst_cmp_reg", REG_COMPARE, 32'h0); step();
`ifdef CP0_TIMER_EN
        mtc0(REG_COMPARE, 32'hFFFF_FFFF);
`endif

        // Interrupt entry
        we = 1'b1; addr = REG_SR; wdata = 32'h0000_0401;
        push("int_pre_req", K_REQ, 0); step();
        we = 1'b0; hwint = NHW'(1); vpc = 32'h3010;
        rd("int_sr", REG_SR, 32'h0000_0401); push("int_req", K_REQ, 1); step();
        rd("int_sr_exl", REG_SR, 32'h0000_0403); push("int_req_held", K_REQ, 0);
        push("int_epc_out", K_EPC, 32'h3010); step();
        rd("int_cause", REG_CAUSE, 32'h0000_0400); step();
        rd("int_epc", REG_EPC, 32'h3010); hwint = '0; eret = 1'b1; step();
        eret = 1'b0; rd("eret_sr", REG_SR, 32'h0000_0401); push("eret_req", K_REQ, 0); step();

        // Synchronous exception in a delay slot
        exccode_in = EXC_RI; vpc = 32'h3024; bd_in = 1'b1;
        push("ri_req", K_REQ, 1); step();
        exccode_in = '0; bd_in = 1'b0;
        rd("ri_cause", REG_CAUSE, 32'h8000_0028); step();
        rd("ri_epc", REG_EPC, 32'h3020); push("ri_epc_out", K_EPC, 32'h3020);
        exccode_in = EXC_OV; push("exl_blocks_req", K_REQ, 0); step();
        exccode_in = '0; eret = 1'b1; step(); eret = 1'b0;

        // Interrupt beats exception; concurrent mtc0 EPC dropped
        hwint = NHW'(1); exccode_in = EXC_OV; vpc = 32'h3040;
        we = 1'b1; addr = REG_EPC; wdata = 32'h5000;
        push("pri_req", K_REQ, 1); push("pri_bypass", K_EPC, 32'h5000); step();
        we = 1'b0; hwint = '0; exccode_in = '0;
        rd("pri_cause", REG_CAUSE, 32'h0000_0400); step();
        rd("pri_epc", REG_EPC, 32'h3040); step();

        // mtc0 EPC together with eret
        we = 1'b1; addr = REG_EPC; wdata = 32'h3105; eret = 1'b1;
        push("eret_bypass", K_EPC, 32'h3104); push("no_wthru", K_RD, 32'h3040);
        push("eret_req_exl", K_REQ, 0); step();
        we = 1'b0; eret = 1'b0;
        rd("eret2_sr", REG_SR, 32'h0000_0401); step();
        rd("eret2_epc", REG_EPC, 32'h3104); push("eret2_epc_out", K_EPC, 32'h3104); step();

        // Ignored writes and SR field masking
        mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        rd("cause_ro", REG_CAUSE, 32'h0); step();
        mtc0(REG_PRID, 32'h0);
        rd("prid_ro", REG_PRID, PRID); step();
        rd("bad_idx", 5'd3, 32'h0); step();
        mtc0(REG_SR, 32'hFFFF_FFFF);
        rd("sr_mask", REG_SR, 32'h0000_FC03); step();

        // Asynchronous reset while EXL is set
        addr = REG_SR; reset = 1'b0;
        push("async_sr", K_RD, 32'h0); push("async_epc", K_EPC, 32'h0);
        push("async_req", K_REQ, 0);
        step();
        reset = 1'b1; step();

`ifdef CP0_TIMER_EN
        // Count/Compare timer
        mtc0(REG_COMPARE, 32'd20);
        mtc0(REG_SR, 32'h0000_8001);
        mtc0(REG_COUNT, 32'd0);
        for (int k = 0; k <= 20; k++) begin
            push("tmr_quiet", K_REQ, 0); step();
        end
        push("tmr_fire", K_REQ, 1); step();
        rd("tmr_cause", REG_CAUSE, 32'h0000_8000); step();
        mtc0(REG_COMPARE, 32'd1000);
        rd("tmr_clear", REG_CAUSE, 32'h0); eret = 1'b1; step();
        eret = 1'b0; push("tmr_req_off", K_REQ, 0); step();
`endif

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Parametrised coprocessor-0 for the 5-stage MIPS core, positioned at the M stage.
- Holds SR (12), Cause (13), EPC (14) and PRId (15).
- Arbitrates external hardware interrupts against the exception code carried down the pipe, and raises a single flush request.
- Generalised over interrupt-line count and PRId value, with an optional Count/Compare timer.

Parameters:
NUM_HWINT, 6, number of hardware interrupt lines, legal 1..6, mapped to IP/IM bits [10+NUM_HWINT-1:10]
PRID_VAL, 32'h0000_7000, constant returned on reads of register 15
EXC_W, 5, exception code width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
we  in  1  mtc0 write enable (M stage)
addr  in  5  CP0 register index for mfc0/mtc0
wdata  in  32  mtc0 write data
rdata  out  32  mfc0 read data, combinational
vpc  in  32  PC of the M-stage instruction
bd_in  in  1  M-stage instruction is in a delay slot
exccode_in  in  EXC_W  exception code from the pipe; 0 = none
hwint  in  NUM_HWINT  level-sensitive interrupt lines
eret  in  1  M-stage instruction is eret
req  out  1  take exception/interrupt now; core flushes and redirects to 0x4180
epc_out  out  32  return address for eret

Behaviour:
- Reset (async on reset=0): SR, Cause and EPC are cleared to 0. rdata reads 0 for every addr except 15, which returns PRID_VAL.
- SR fields: IM = [10+N-1:10], EXL = bit 1, IE = bit 0; all other bits read 0.
- Cause fields: BD = bit 31, IP = [10+N-1:10], ExcCode = [6:2]; all other bits read 0.
- IP: IP <= hwint on every clock edge unconditionally, so it lags the lines by one cycle.
- int_req = IE & ~EXL & |(hwint & IM). This uses the live hwint, not IP.
- exc_req = ~EXL & (exccode_in != 0).
- req = int_req | exc_req, combinational with 0-cycle latency.
- Priority: an interrupt beats a synchronous exception.
- On a clock edge with req=1:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exccode_in.
  - BD <= bd_in.
  - EPC <= bd_in ? vpc-4 : vpc, with bits [1:0] forced to 0.
- mtc0 (we=1) on a clock edge:
  - Writes SR (only IM/EXL/IE are stored) or EPC (bits [1:0] forced to 0).
  - Writes to Cause, PRId or any other index are ignored.
  - If req=1 in the same cycle, the write is dropped; the exception wins.
- eret on a clock edge with req=0: EXL <= 0.
- eret and req in the same cycle: req wins and EXL stays 1. This is only reachable when EXL=0 already.
- epc_out = (we && addr==14) ? {wdata[31:2],2'b00} : EPC. This bypass lets an mtc0 EPC followed by eret resolve correctly.
- rdata returns the registered value before any same-cycle write; there is no write-through.
- Illegal read index returns 0.
- reset asserted mid-exception clears EXL immediately, without waiting for a clock edge.

Optional Feature:
Macro: CP0_TIMER_EN.

Enabled:
- Adds Count (reg 9) and Compare (reg 11).
- Count increments every cycle and wraps at 2^32.
- mtc0 to Count loads it on that edge; the increment is suppressed that cycle.
- mtc0 to Compare loads Compare and clears timer_pend.
- timer_pend sets on the edge where Count == Compare.
- timer_pend drives IP[15] and participates in int_req, masked by IM[15].
- Requires NUM_HWINT <= 5; otherwise elaboration fails via generate-time error.
- Reset clears Count, Compare and timer_pend.

Disabled:
- Registers 9 and 11 read 0 and ignore writes.
- Bit 15 behaves as an ordinary line when NUM_HWINT=6.

Decomposition:
Package cp0_pkg holds:
- Register indices: SR=12, CAUSE=13, EPC=14, PRID=15, COUNT=9, COMPARE=11.
- Field bit positions: IE=0, EXL=1, IM/IP base=10, BD=31, ExcCode [6:2].
- EXCCODE constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
- Handler address 32'h0000_4180.

Sub-module cp0_timer (Count/Compare/timer_pend) is instantiated only under CP0_TIMER_EN.

Test Plan:
1. Reset release, then read addr 12/13/14/15 → 0/0/0/PRID_VAL; req=0 with hwint=0 and exccode_in=0.
2. mtc0 SR=0x0000_0401 (IM[10]=1, IE=1), hwint[0]=1, vpc=0x3010, bd_in=0 → req=1 same cycle. Next cycle: EXL=1, ExcCode=0, EPC=0x3010, req=0 even though hwint is held high.
3. exccode_in=10 (RI), vpc=0x3024, bd_in=1 → req=1. Next cycle: Cause=0x8000_0028, EPC=0x3020.
4. Same cycle hwint[0]=1 (unmasked) and exccode_in=12 → ExcCode recorded 0. Concurrent mtc0 EPC=0x5000 is dropped; EPC=vpc.
5. EXL=1, mtc0 EPC=0x3105 with eret the same cycle → epc_out=0x3104 that cycle; next cycle EXL=0 and EPC=0x3104.
6. (CP0_TIMER_EN, NUM_HWINT=5) Compare=20, IM[15]=1, IE=1, Count written 0 → req rises 21 cycles after the Count write. mtc0 Compare clears the pending request.
